vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters,
// registered active-low syncs and bright gate, frame strobe, and a
// pixel-tick delay line that aligns sync/bright with registered ROM data.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned DELAY    = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       frame_tick,
  output logic       bright_d,
  output logic       hSync_d,
  output logic       vSync_d
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_FIRST = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_FIRST = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          frame_wrap;

  assign pixel_tick = (div_cnt == DIV_LAST);

  // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pixel_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Next counter values; equality compares so a wrap can never be skipped.
  always_comb begin
    h_nxt      = hCount;
    v_nxt      = vCount;
    frame_wrap = 1'b0;
    if (pixel_tick) begin
      if (hCount == H_LAST) begin
        h_nxt = '0;
        if (vCount == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = vCount + 10'd1;
        end
      end else begin
        h_nxt = hCount + 10'd1;
      end
    end
  end

  // Counters plus syncs/bright decoded from the next counter values, so all
  // of them switch on the same edge without a combinational output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hCount     <= h_nxt;
      vCount     <= v_nxt;
      hSync      <= (h_nxt >= H_SYNC_END);
      vSync      <= (v_nxt >= V_SYNC_END);
      bright     <= (h_nxt >= H_ACT_FIRST) && (h_nxt <= H_ACT_LAST) &&
                    (v_nxt >= V_ACT_FIRST) && (v_nxt <= V_ACT_LAST);
      frame_tick <= frame_wrap;
    end
  end

  generate
    if (DELAY == 0) begin : g_nodelay
      assign hSync_d  = hSync;
      assign vSync_d  = vSync;
      assign bright_d = bright;
    end else begin : g_delay
      // Each stage holds {hSync, vSync, bright}; reset state matches (0,0).
      logic [2:0] dly [DELAY];

      // Delay line advanced once per pixel.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < DELAY; i++) dly[i] <= '0;
        end else if (pixel_tick) begin
          dly[0] <= {hSync, vSync, bright};
          for (int unsigned i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
        end
      end

      assign {hSync_d, vSync_d, bright_d} = dly[DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: shrunken raster geometry, two instances
// (CLK_DIV=4/DELAY=2 and CLK_DIV=3/DELAY=0) checked every clk against an
// arithmetic model driven by clk count since reset, plus random resets.
module tb_vga_timing_gen;

  localparam int HS = 3, HBP = 2, HA = 8, HT = 16;
  localparam int VS = 2, VBP = 1, VA = 4, VT = 9;
  localparam int CD_A = 4, DL_A = 2;
  localparam int CD_B = 3, DL_B = 0;
  localparam int LINE_A  = HT * CD_A;
  localparam int FRAME_A = HT * VT * CD_A;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       tick_a, br_a, hs_a, vs_a, ft_a, brd_a, hsd_a, vsd_a;
  logic [9:0] h_a, v_a;
  logic       tick_b, br_b, hs_b, vs_b, ft_b, brd_b, hsd_b, vsd_b;
  logic [9:0] h_b, v_b;

  int n_cmp = 0;
  int n_err = 0;
  int n     = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(CD_A), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT), .DELAY(DL_A)
  ) dut_a (
    .clk(clk), .rst(rst), .pixel_tick(tick_a), .hCount(h_a), .vCount(v_a),
    .bright(br_a), .hSync(hs_a), .vSync(vs_a), .frame_tick(ft_a),
    .bright_d(brd_a), .hSync_d(hsd_a), .vSync_d(vsd_a)
  );

  vga_timing_gen #(
    .CLK_DIV(CD_B), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT), .DELAY(DL_B)
  ) dut_b (
    .clk(clk), .rst(rst), .pixel_tick(tick_b), .hCount(h_b), .vCount(v_b),
    .bright(br_b), .hSync(hs_b), .vSync(vs_b), .frame_tick(ft_b),
    .bright_d(brd_b), .hSync_d(hsd_b), .vSync_d(vsd_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (n=%0d, t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  // Raster state of pixel number p counted from the reset origin.
  function automatic void pix(input int p, output int h, output int v,
                              output int br, output int hs, output int vs);
    h  = p % HT;
    v  = (p / HT) % VT;
    hs = (h >= HS) ? 1 : 0;
    vs = (v >= VS) ? 1 : 0;
    br = (h >= HS + HBP && h < HS + HBP + HA &&
          v >= VS + VBP && v < VS + VBP + VA) ? 1 : 0;
  endfunction

  // Expected outputs in the clk that follows n edges since the reset edge.
  function automatic void model(input int cnt, input int cd, input int dl,
                                output int tk, output int h, output int v,
                                output int br, output int hs, output int vs,
                                output int ft, output int brd, output int hsd,
                                output int vsd);
    int p;
    int dh;
    int dv;
    p  = cnt / cd;
    tk = (cnt % cd == cd - 1) ? 1 : 0;
    ft = (cnt > 0 && cnt % cd == 0 && p % (HT * VT) == 0) ? 1 : 0;
    pix(p, h, v, br, hs, vs);
    pix((p > dl) ? p - dl : 0, dh, dv, brd, hsd, vsd);
  endfunction

  // Clk count since the last edge that sampled rst high.
  always @(posedge clk) begin
    if (rst) begin
      n     <= 0;
      armed <= 1'b1;
    end else begin
      n <= n + 1;
    end
  end

  // Per-clk comparison of both instances against the model.
  always @(negedge clk) begin
    int tk, h, v, br, hs, vs, ft, brd, hsd, vsd;
    if (armed) begin
      model(n, CD_A, DL_A, tk, h, v, br, hs, vs, ft, brd, hsd, vsd);
      check("A_tick", int'(tick_a), tk);
      check("A_h",    int'(h_a),    h);
      check("A_v",    int'(v_a),    v);
      check("A_br",   int'(br_a),   br);
      check("A_hs",   int'(hs_a),   hs);
      check("A_vs",   int'(vs_a),   vs);
      check("A_ft",   int'(ft_a),   ft);
      check("A_brd",  int'(brd_a),  brd);
      check("A_hsd",  int'(hsd_a),  hsd);
      check("A_vsd",  int'(vsd_a),  vsd);
      model(n, CD_B, DL_B, tk, h, v, br, hs, vs, ft, brd, hsd, vsd);
      check("B_tick", int'(tick_b), tk);
      check("B_h",    int'(h_b),    h);
      check("B_v",    int'(v_b),    v);
      check("B_br",   int'(br_b),   br);
      check("B_hs",   int'(hs_b),   hs);
      check("B_vs",   int'(vs_b),   vs);
      check("B_ft",   int'(ft_b),   ft);
      check("B_brd",  int'(brd_b),  brd);
      check("B_hsd",  int'(hsd_b),  hsd);
      check("B_vsd",  int'(vsd_b),  vsd);
    end
  end

  initial begin
    int bright_clks;
    int hlow_clks;
    int ft1;
    int ft2;
    bright_clks = 0;
    hlow_clks   = 0;
    ft1 = -1;
    ft2 = -1;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // Two full frames of aggregate timing on instance A.
    for (int i = 0; i < 2 * FRAME_A + 8; i++) begin
      @(negedge clk);
      if (br_a && n < FRAME_A) bright_clks++;
      if (!hs_a && n >= LINE_A && n < 2 * LINE_A) hlow_clks++;
      if (ft_a) begin
        if (ft1 < 0) ft1 = n;
        else if (ft2 < 0) ft2 = n;
      end
    end
    check("bright_clks_per_frame", bright_clks, HA * VA * CD_A);
    check("hsync_low_clks_per_line", hlow_clks, HS * CD_A);
    check("first_frame_tick_at", ft1, FRAME_A);
    check("frame_tick_spacing", ft2 - ft1, FRAME_A);

    // Random reset pulses at arbitrary raster positions and divider phases.
    repeat (25) begin
      rst = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(20, 900)) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
